bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//   Four-requester round-robin arbiter for a shared 8-bit tri-state bus.
//   A tenure lasts while the owner holds its request. Every tenure is
//   followed by a one-cycle turnaround (TURN) so two bus drivers are never
//   enabled back to back.
//
//   Optional feature: define ARB_TIMEOUT_EN to bound every tenure to
//   MAX_HOLD cycles. The owner is revoked and a one-cycle timeout pulse is
//   raised. Without the macro, tenures are unbounded and timeout is 0.
//
// Parameters
//   MAX_HOLD   maximum GRANT cycles per tenure (2..15), timeout build only
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   req[3:0]   per-requester bus request, held for the whole tenure
//   gnt[3:0]   registered one-hot-or-zero grant (bus driver enable)
//   bus_sel    registered index of current owner, 0 when idle
//   bus_busy   registered OR of gnt
//   timeout    registered one-cycle pulse on a forced revoke
//   dbg_state  current FSM state (0 IDLE, 1 GRANT, 2 TURN)
//
// Handshake: req[i] is a level request; the tenure begins on the cycle gnt[i]
// is first seen high and ends on the edge that samples req[i] low (or on
// a timeout revoke). gnt is never combinationally dependent on req.
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] bus_sel,
   output logic       bus_busy,
   output logic       timeout,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_gnt, w_gnt_nxt;
   logic [1:0] r_sel, w_sel_nxt;
   logic [1:0] r_ptr, w_ptr_nxt;
   logic       r_busy;
   logic       r_timeout, w_timeout_nxt;
   logic       w_any;
   logic [1:0] w_win;
   logic [1:0] w_idx;

`ifdef ARB_TIMEOUT_EN
   logic [3:0] r_cnt, w_cnt_nxt;
`endif

   // Winner: first set request bit at or above r_ptr, wrapping 3->0. The
   // loop runs from the farthest offset down so the nearest one wins.
   always_comb begin
      w_any = |req;
      w_win = r_ptr;
      w_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_ptr + 2'(k);
         if (req[w_idx]) w_win = w_idx;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_sel_nxt     = r_sel;
      w_ptr_nxt     = r_ptr;
      w_timeout_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
      w_cnt_nxt     = r_cnt;
`endif
      case (r_state)
         ST_IDLE, ST_TURN: begin
            if (w_any) begin
               w_state_nxt = ST_GRANT;
               w_gnt_nxt   = 4'b0001 << w_win;
               w_sel_nxt   = w_win;
               w_ptr_nxt   = w_win + 2'd1;
`ifdef ARB_TIMEOUT_EN
               w_cnt_nxt   = 4'd0;
`endif
            end else begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = 4'b0000;
               w_sel_nxt   = 2'd0;
            end
         end
         ST_GRANT: begin
            // A normal release takes precedence over a timeout that would
            // fire on the same edge.
            if (!req[r_sel]) begin
               w_state_nxt = ST_TURN;
               w_gnt_nxt   = 4'b0000;
               w_sel_nxt   = 2'd0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (r_cnt == 4'(MAX_HOLD - 1)) begin
               // r_ptr already points past this owner, so it re-competes last.
               w_state_nxt   = ST_TURN;
               w_gnt_nxt     = 4'b0000;
               w_sel_nxt     = 2'd0;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
`endif
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
            w_sel_nxt   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_gnt     <= 4'b0000;
         r_sel     <= 2'd0;
         r_ptr     <= 2'd0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_cnt     <= 4'd0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_sel     <= w_sel_nxt;
         r_ptr     <= w_ptr_nxt;
         r_busy    <= |w_gnt_nxt;
         r_timeout <= w_timeout_nxt;
`ifdef ARB_TIMEOUT_EN
         r_cnt     <= w_cnt_nxt;
`endif
      end
   end

   assign gnt       = r_gnt;
   assign bus_sel   = r_sel;
   assign bus_busy  = r_busy;
   assign timeout   = r_timeout;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] bus_sel;
  logic       bus_busy;
  logic       timeout;
  logic [1:0] dbg_state;

  int checks;
  int failures;

  bus_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .bus_sel(bus_sel),
    .bus_busy(bus_busy), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // invariants sampled every cycle away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (($countones(gnt) > 1) !== 1'b0) begin
        failures++;
        $display("FAIL onehot0_gnt got=%b required=onehot0", gnt);
      end
      checks++;
      if (bus_busy !== (|gnt)) begin
        failures++;
        $display("FAIL busy_eq_or_gnt got=%b required=%b", bus_busy, |gnt);
      end
    end
  end

  task automatic chk_gnt(input string name, input logic [3:0] eg, input logic [1:0] es);
    checks++;
    if (gnt !== eg) begin
      failures++;
      $display("FAIL %s gnt got=%b required=%b", name, gnt, eg);
    end
    checks++;
    if (bus_sel !== es) begin
      failures++;
      $display("FAIL %s bus_sel got=%0d required=%0d", name, bus_sel, es);
    end
  endtask

  task automatic go_idle();
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({gnt, bus_sel, bus_busy, timeout, dbg_state} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state got=%b required=%b",
               {gnt, bus_sel, bus_busy, timeout, dbg_state}, 10'b0);
    end
    req = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
    chk_gnt("idle_after_reset", 4'b0000, 2'd0);
  endtask

  task automatic test_basic();
    req = 4'b0101;
    @(negedge clk);
    chk_gnt("basic_first_grant", 4'b0001, 2'd0);
    @(negedge clk);
    chk_gnt("basic_hold", 4'b0001, 2'd0);
    req = 4'b0100;
    @(negedge clk);
    chk_gnt("basic_turn", 4'b0000, 2'd0);
    checks++;
    if (dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL basic_turn_state got=%0d required=2", dbg_state);
    end
    @(negedge clk);
    chk_gnt("basic_second_grant", 4'b0100, 2'd2);
    go_idle();
    chk_gnt("basic_idle", 4'b0000, 2'd0);
  endtask

  // pointer is 3 here (last owner was requester 2)
  task automatic test_wrap();
    req = 4'b0011;
    @(negedge clk);
    chk_gnt("wrap_to_0", 4'b0001, 2'd0);
    req = 4'b0010;
    @(negedge clk);
    chk_gnt("wrap_turn", 4'b0000, 2'd0);
    @(negedge clk);
    chk_gnt("wrap_then_1", 4'b0010, 2'd1);
    go_idle();
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    sync_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      eg = 4'b0001 << (i % 4);
      @(negedge clk);
      chk_gnt("fair_grant", eg, 2'(i % 4));
      @(negedge clk);
      chk_gnt("fair_hold", eg, 2'(i % 4));
      req = 4'b1111 & ~eg;
      @(negedge clk);
      chk_gnt("fair_gap", 4'b0000, 2'd0);
      req = 4'b1111;
    end
    go_idle();
  endtask

  task automatic test_timeout();
    sync_reset();
    req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_gnt("to_hold", 4'b0001, 2'd0);
      checks++;
      if (timeout !== 1'b0) begin
        failures++;
        $display("FAIL to_early got=%b required=0", timeout);
      end
    end
    @(negedge clk);
    chk_gnt("to_revoke", 4'b0000, 2'd0);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_pulse got=%b required=1", timeout);
    end
    @(negedge clk);
    chk_gnt("to_next_owner", 4'b0010, 2'd1);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse_len got=%b required=0", timeout);
    end
    // release on the very cycle the timeout would fire
    req = 4'b0010;
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk_gnt("to_edge_hold", 4'b0010, 2'd1);
    req = 4'b0000;
    @(negedge clk);
    chk_gnt("to_edge_release", 4'b0000, 2'd0);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_edge_no_pulse got=%b required=0", timeout);
    end
`else
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_gnt("notimeout_hold", 4'b0001, 2'd0);
      checks++;
      if (timeout !== 1'b0) begin
        failures++;
        $display("FAIL notimeout_pulse got=%b required=0", timeout);
      end
    end
`endif
    go_idle();
  endtask

  task automatic test_async_reset();
    req = 4'b0100;
    @(negedge clk);
    chk_gnt("ar_pre_grant", 4'b0100, 2'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, bus_busy, bus_sel} !== 7'b0) begin
      failures++;
      $display("FAIL ar_immediate got=%b required=%b", {gnt, bus_busy, bus_sel}, 7'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1000;
    @(negedge clk);
    chk_gnt("ar_after_release", 4'b1000, 2'd3);
    go_idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    test_reset();
    test_basic();
    test_wrap();
    test_fairness();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
